// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-Lite initiator driving single and INCR/WRAP bursts from a valid/ready command port
module ahb_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  typedef enum logic [1:0] {IDLE, ADDR, LAST, ERR} state_t;
  state_t state, state_nx;
  logic dp, dp_write, accept, addr_acc, err_hit, rd_beat;
  logic [4:0] rem, beats_c;
  logic [2:0] size_c;
  logic [ADDR_W-1:0] step, span, mask, addr_nx;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign addr_acc = HTRANS[1] && HREADY;
  assign wr_pop = addr_acc && HWRITE;
  assign err_hit = (state == ADDR || state == LAST) && dp && HRESP && !HREADY;
  assign rd_beat = dp && !dp_write && HREADY && !HRESP;
  assign HPROT = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign size_c = cmd_size > MAX_SIZE ? MAX_SIZE : cmd_size;
  assign beats_c = cmd_burst[2:1] == 2'd0 ? 5'd1 : 5'd2 << cmd_burst[2:1];
  assign step = ADDR_W'(1) << HSIZE;
  assign span = (HBURST[2:1] == 2'd0 ? ADDR_W'(1) : ADDR_W'(2) << HBURST[2:1]) << HSIZE;
  assign mask = span - ADDR_W'(1);
  assign addr_nx = HBURST[0] ? HADDR + step : (HADDR & ~mask) | ((HADDR + step) & mask);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (cmd_burst[2:1] == 2'd0 ? LAST : ADDR) : IDLE;
      ADDR: state_nx = err_hit ? ERR : addr_acc && rem == 5'd1 ? LAST : ADDR;
      LAST: state_nx = err_hit ? ERR : HREADY && !HTRANS[1] ? IDLE : LAST;
      ERR:  state_nx = HREADY ? IDLE : ERR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      HADDR <= '0;
      HTRANS <= 2'b00;
      HWRITE <= 1'b0;
      HSIZE <= 3'd0;
      HBURST <= 3'd0;
      HWDATA <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      dp <= 1'b0;
      dp_write <= 1'b0;
      rem <= 5'd0;
    end else begin
      rd_valid <= rd_beat;
      done <= state == LAST && HREADY && !HTRANS[1];
      err <= state == ERR && HREADY;
      if (rd_beat) rd_data <= HRDATA;
      if (accept) begin
        HADDR <= cmd_addr & ~((ADDR_W'(1) << size_c) - ADDR_W'(1));
        HTRANS <= 2'b10;
        HWRITE <= cmd_write;
        HSIZE <= size_c;
        HBURST <= cmd_burst == 3'b001 ? 3'b000 : cmd_burst;
        rem <= beats_c;
      end else if (err_hit) HTRANS <= 2'b00;
      else if (HREADY) begin
        dp <= HTRANS[1];
        if (addr_acc) begin
          dp_write <= HWRITE;
          if (HWRITE) HWDATA <= wr_data;
          rem <= rem - 5'd1;
          HTRANS <= rem == 5'd1 ? 2'b00 : 2'b11;
          if (rem != 5'd1) HADDR <= addr_nx;
        end
      end
    end
endmodule
